// File: rtl/sprite_actor.sv
// sprite_actor: tick-driven game sprite that applies one user command per tick,
// then streams its 16x16 bitmap from sprite memory into pixel writes.
module sprite_actor #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int FRAMES = 2,
  parameter int STEP = 1,
  parameter int X_MIN = 0,
  parameter int X_MAX = 303,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 223,
  parameter int X_INIT = 1,
  parameter int Y_INIT = 96,
  parameter int ATK_TICKS = 4,
  parameter int ANIM_DIV = 4,
  parameter logic [5:0] TRANSP = 6'h3F,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              start,
  input  logic              c_attack,
  input  logic              c_up,
  input  logic              c_down,
  input  logic              c_left,
  input  logic              c_right,
  input  logic              blocked,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [5:0]        mem_q,
  output logic [8:0]        x_pos,
  output logic [7:0]        y_pos,
  output logic [1:0]        facing,
  output logic              attacking,
  output logic [8:0]        x_draw,
  output logic [7:0]        y_draw,
  output logic [5:0]        colour,
  output logic              VGA_write,
  output logic              busy,
  output logic              done
);
  localparam int NPIX = SPR_W * SPR_H;
  localparam int KW = $clog2(NPIX);
  localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int AW = $clog2(ANIM_DIV + 1);
  localparam int TW = $clog2(ATK_TICKS + 1);

  typedef enum logic [2:0] {IDLE, APPLY, DRAW, FLUSH, DONE} state_t;

  state_t state;
  logic [4:0] cmd;
  logic [KW-1:0] k;
  logic [FW-1:0] frame;
  logic [AW-1:0] anim_cnt;
  logic [TW-1:0] atk_cnt;
  logic pend, is_mv, anim_wrap;
  logic [1:0] dir;
  logic [8:0] x_dec, x_inc;
  logic [7:0] y_dec, y_inc;

  // cmd is {attack, up, down, left, right}; attack outranks any direction
  always_comb begin
    is_mv = !cmd[4] && |cmd[3:0];
    dir = cmd[3] ? 2'd2 : cmd[2] ? 2'd0 : cmd[1] ? 2'd1 : 2'd3;
    anim_wrap = int'(anim_cnt) == ANIM_DIV - 1;
    x_dec = int'(x_pos) - STEP < X_MIN ? 9'(X_MIN) : 9'(int'(x_pos) - STEP);
    x_inc = int'(x_pos) + STEP > X_MAX ? 9'(X_MAX) : 9'(int'(x_pos) + STEP);
    y_dec = int'(y_pos) - STEP < Y_MIN ? 8'(Y_MIN) : 8'(int'(y_pos) - STEP);
    y_inc = int'(y_pos) + STEP > Y_MAX ? 8'(Y_MAX) : 8'(int'(y_pos) + STEP);
  end

  assign busy = state != IDLE;
  assign colour = mem_q;
  assign VGA_write = pend && mem_q != TRANSP;
  assign mem_addr = state == DRAW ?
    ADDR_W'(((int'(facing) * 2 + int'(attacking)) * FRAMES + int'(frame)) * NPIX + int'(k)) : '0;

  always_ff @(posedge clock) begin
    if (reset || init) begin
      state <= IDLE;
      cmd <= '0;
      k <= '0;
      x_pos <= 9'(X_INIT);
      y_pos <= 8'(Y_INIT);
      facing <= '0;
      attacking <= 1'b0;
      frame <= '0;
      anim_cnt <= '0;
      atk_cnt <= '0;
      pend <= 1'b0;
      done <= 1'b0;
      x_draw <= '0;
      y_draw <= '0;
    end else begin
      done <= state == FLUSH;
      pend <= state == DRAW;
      if (state == DRAW) begin
        x_draw <= 9'(int'(x_pos) + int'(k) % SPR_W);
        y_draw <= 8'(int'(y_pos) + int'(k) / SPR_W);
      end
      case (state)
        IDLE: if (start) begin
          cmd <= {c_attack, c_up, c_down, c_left, c_right};
          state <= APPLY;
        end
        APPLY: begin
          state <= DRAW;
          k <= '0;
          if (attacking) begin
            atk_cnt <= atk_cnt - 1'b1;
            attacking <= atk_cnt != TW'(1);
          end
          if (cmd[4] && !attacking) begin
            atk_cnt <= TW'(ATK_TICKS);
            attacking <= 1'b1;
          end else if (is_mv && !attacking) begin
            facing <= dir;
            anim_cnt <= anim_wrap ? '0 : anim_cnt + 1'b1;
            frame <= anim_wrap ? FW'((int'(frame) + 1) % FRAMES) : frame;
            if (!blocked) begin
              x_pos <= dir == 2'd1 ? x_dec : dir == 2'd3 ? x_inc : x_pos;
              y_pos <= dir == 2'd2 ? y_dec : dir == 2'd0 ? y_inc : y_pos;
            end
          end else if (!cmd[4] && !is_mv) begin
            anim_cnt <= '0;
            frame <= '0;
          end
        end
        DRAW: begin
          k <= k + 1'b1;
          if (k == KW'(NPIX - 1)) state <= FLUSH;
        end
        FLUSH: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_actor.sv
// tb_sprite_actor: vector table, hand sequences and random ticks checked against a
// command-level model of the sprite's position, facing, attack and animation state.
module tb_sprite_actor;
  logic clock = 0, reset = 1, init = 0, start = 0, e_start = 0, blocked = 0;
  logic c_attack = 0, c_up = 0, c_down = 0, c_left = 0, c_right = 0;
  logic [12:0] mem_addr, e_mem_addr;
  logic [5:0] mem_q = 0, e_q = 0, colour, e_colour;
  logic [8:0] x_pos, x_draw, e_x, e_xd;
  logic [7:0] y_pos, y_draw, e_y, e_yd;
  logic [1:0] facing, e_facing;
  logic attacking, VGA_write, busy, done, e_att, e_wr, e_busy, e_done;

  int pass_cnt = 0, total = 0, pat = 0;
  int mx = 1, my = 96, mf = 0, ma = 0, mfr = 0, man = 0, matk = 0;

  typedef struct {logic [4:0] cmd; logic blk; int x, y, f, a, fr;} vec_t;
  vec_t tbl[30];

  sprite_actor dut (
    .clock(clock), .reset(reset), .init(init), .start(start),
    .c_attack(c_attack), .c_up(c_up), .c_down(c_down), .c_left(c_left), .c_right(c_right),
    .blocked(blocked), .mem_addr(mem_addr), .mem_q(mem_q), .x_pos(x_pos), .y_pos(y_pos),
    .facing(facing), .attacking(attacking), .x_draw(x_draw), .y_draw(y_draw),
    .colour(colour), .VGA_write(VGA_write), .busy(busy), .done(done)
  );

  sprite_actor #(.X_INIT(302), .Y_INIT(222)) dut_edge (
    .clock(clock), .reset(reset), .init(init), .start(e_start),
    .c_attack(c_attack), .c_up(c_up), .c_down(c_down), .c_left(c_left), .c_right(c_right),
    .blocked(blocked), .mem_addr(e_mem_addr), .mem_q(e_q), .x_pos(e_x), .y_pos(e_y),
    .facing(e_facing), .attacking(e_att), .x_draw(e_xd), .y_draw(e_yd),
    .colour(e_colour), .VGA_write(e_wr), .busy(e_busy), .done(e_done)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] memval(input int a, input int p);
    return p == 1 ? ((a % 2 == 1) ? 6'h3F : 6'(a % 32)) : 6'((a * 5 + 1) % 64);
  endfunction

  always @(posedge clock) mem_q <= memval(int'(mem_addr), pat);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_cmd(input logic [4:0] cmd);
    {c_attack, c_up, c_down, c_left, c_right} = cmd;
  endtask

  function automatic void model_reset();
    mx = 1; my = 96; mf = 0; ma = 0; mfr = 0; man = 0; matk = 0;
  endfunction

  // One game tick at the command level: attack countdown, then the chosen action
  function automatic void model_apply(input logic [4:0] cmd, input logic blk);
    int was = ma;
    if (was != 0) begin
      matk--;
      if (matk == 0) ma = 0;
    end
    if (cmd[4]) begin
      if (was == 0) begin matk = 4; ma = 1; end
    end else if (cmd[3:0] != 0) begin
      if (was == 0) begin
        if (cmd[3]) begin mf = 2; if (!blk) my = my - 1 < 0 ? 0 : my - 1; end
        else if (cmd[2]) begin mf = 0; if (!blk) my = my + 1 > 223 ? 223 : my + 1; end
        else if (cmd[1]) begin mf = 1; if (!blk) mx = mx - 1 < 0 ? 0 : mx - 1; end
        else begin mf = 3; if (!blk) mx = mx + 1 > 303 ? 303 : mx + 1; end
        man = (man + 1) % 4;
        if (man == 0) mfr = (mfr + 1) % 2;
      end
    end else begin
      man = 0; mfr = 0;
    end
  endfunction

  task automatic do_tick(input logic [4:0] cmd, input logic blk, input int p, input int gc,
                         output int first_addr, output int nwr);
    int base, ewr, ea, pp;
    bit ok_addr, ok_busy, ok_done, ok_wr, ew;
    ok_addr = 1; ok_busy = 1; ok_done = 1; ok_wr = 1;
    pat = p;
    @(negedge clock);
    drive_cmd(cmd); blocked = blk; start = 1;
    model_apply(cmd, blk);
    base = ((mf * 2 + ma) * 2 + mfr) * 256;
    first_addr = -1; nwr = 0; ewr = 0;
    for (int c = 1; c <= 261; c++) begin
      @(negedge clock);
      if (c == 1) begin start = 0; drive_cmd(5'($urandom)); end
      if (c == 2) blocked = 1'($urandom);
      if (c == gc) begin start = 1; drive_cmd(5'($urandom)); end
      if (c == gc + 1) start = 0;
      ea = (c >= 2 && c <= 257) ? base + c - 2 : 0;
      if (int'(mem_addr) != ea) ok_addr = 0;
      if (c == 2) first_addr = int'(mem_addr);
      if (busy !== (c <= 259)) ok_busy = 0;
      if (done !== (c == 259)) ok_done = 0;
      if (VGA_write === 1'b1) nwr++;
      if (c >= 3 && c <= 258) begin
        pp = c - 3;
        ew = memval(base + pp, p) != 6'h3F;
        if (ew) ewr++;
        if (VGA_write !== ew || (ew && (x_draw !== 9'(mx + pp % 16) || y_draw !== 8'(my + pp / 16))))
          ok_wr = 0;
      end else if (VGA_write !== 1'b0) ok_wr = 0;
    end
    check("mem_addr_seq", ok_addr, 1);
    check("busy_window", ok_busy, 1);
    check("done_at_259", ok_done, 1);
    check("pixel_writes", ok_wr, 1);
    check("write_count", nwr, ewr);
    check("x_pos", int'(x_pos), mx);
    check("y_pos", int'(y_pos), my);
    check("facing", int'(facing), mf);
    check("attacking", int'(attacking), ma);
  endtask

  task automatic e_tick(input logic [4:0] cmd, input logic blk, input int ex, input int ey, input int ef);
    int n = 0;
    @(negedge clock);
    drive_cmd(cmd); blocked = blk; e_start = 1;
    @(negedge clock);
    e_start = 0;
    while (e_done !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    check("edge_done_seen", int'(n < 400), 1);
    check("edge_x", int'(e_x), ex);
    check("edge_y", int'(e_y), ey);
    check("edge_facing", int'(e_facing), ef);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, nw, cnt, base, r;
    logic [4:0] rc;
    tbl[0]  = '{5'b00001, 1'b0, 2, 96, 3, 0, 0};
    tbl[1]  = '{5'b01000, 1'b1, 2, 96, 2, 0, 0};
    tbl[2]  = '{5'b10000, 1'b0, 2, 96, 2, 1, 0};
    tbl[3]  = '{5'b00010, 1'b0, 2, 96, 2, 1, 0};
    tbl[4]  = '{5'b00010, 1'b0, 2, 96, 2, 1, 0};
    tbl[5]  = '{5'b00010, 1'b0, 2, 96, 2, 1, 0};
    tbl[6]  = '{5'b00010, 1'b0, 2, 96, 2, 0, 0};
    tbl[7]  = '{5'b00010, 1'b0, 1, 96, 1, 0, 0};
    tbl[8]  = '{5'b00010, 1'b0, 0, 96, 1, 0, 1};
    tbl[9]  = '{5'b00010, 1'b0, 0, 96, 1, 0, 1};
    tbl[10] = '{5'b00000, 1'b0, 0, 96, 1, 0, 0};
    tbl[11] = '{5'b00100, 1'b0, 0, 97, 0, 0, 0};
    tbl[12] = '{5'b00100, 1'b0, 0, 98, 0, 0, 0};
    tbl[13] = '{5'b00100, 1'b0, 0, 99, 0, 0, 0};
    tbl[14] = '{5'b00100, 1'b0, 0, 100, 0, 0, 1};
    tbl[15] = '{5'b00100, 1'b0, 0, 101, 0, 0, 1};
    tbl[16] = '{5'b00100, 1'b0, 0, 102, 0, 0, 1};
    tbl[17] = '{5'b00100, 1'b0, 0, 103, 0, 0, 1};
    tbl[18] = '{5'b00100, 1'b0, 0, 104, 0, 0, 0};
    tbl[19] = '{5'b00000, 1'b0, 0, 104, 0, 0, 0};
    tbl[20] = '{5'b10001, 1'b0, 0, 104, 0, 1, 0};
    tbl[21] = '{5'b00000, 1'b0, 0, 104, 0, 1, 0};
    tbl[22] = '{5'b00000, 1'b0, 0, 104, 0, 1, 0};
    tbl[23] = '{5'b00000, 1'b0, 0, 104, 0, 1, 0};
    tbl[24] = '{5'b00000, 1'b0, 0, 104, 0, 0, 0};
    tbl[25] = '{5'b01111, 1'b0, 0, 103, 2, 0, 0};
    tbl[26] = '{5'b00110, 1'b0, 0, 104, 0, 0, 0};
    tbl[27] = '{5'b00011, 1'b0, 0, 104, 1, 0, 0};
    tbl[28] = '{5'b00001, 1'b1, 0, 104, 3, 0, 1};
    tbl[29] = '{5'b00001, 1'b0, 1, 104, 3, 0, 1};

    repeat (3) @(negedge clock);
    reset = 0;
    check("rst_x_pos", int'(x_pos), 1);
    check("rst_y_pos", int'(y_pos), 96);
    check("rst_facing", int'(facing), 0);
    check("rst_attacking", int'(attacking), 0);
    check("rst_busy_done_write", int'({busy, done, VGA_write}), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_draw_xy", int'({x_draw, y_draw}), 0);

    for (int i = 0; i < 30; i++) begin
      do_tick(tbl[i].cmd, tbl[i].blk, i % 2, (i % 7 == 4) ? 60 : (i % 7 == 6) ? 259 : 0, fa, nw);
      check($sformatf("tbl%0d_x", i), int'(x_pos), tbl[i].x);
      check($sformatf("tbl%0d_y", i), int'(y_pos), tbl[i].y);
      check($sformatf("tbl%0d_facing", i), int'(facing), tbl[i].f);
      check($sformatf("tbl%0d_attacking", i), int'(attacking), tbl[i].a);
      check($sformatf("tbl%0d_frame", i), (fa / 256) % 2, tbl[i].fr);
      if (i % 2 == 1) check($sformatf("tbl%0d_transp_128", i), nw, 128);
    end

    // reset at DRAW pixel 100 aborts the frame
    @(negedge clock);
    drive_cmd(5'b00001); blocked = 0; start = 1;
    model_apply(5'b00001, 1'b0);
    base = ((mf * 2 + ma) * 2 + mfr) * 256;
    @(negedge clock);
    start = 0;
    repeat (101) @(negedge clock);
    check("pix100_addr", int'(mem_addr), base + 100);
    reset = 1;
    @(negedge clock);
    reset = 0;
    model_reset();
    check("abort_busy", int'(busy), 0);
    check("abort_x", int'(x_pos), 1);
    check("abort_y", int'(y_pos), 96);
    check("abort_mem_addr", int'(mem_addr), 0);
    cnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (done === 1'b1 || VGA_write === 1'b1) cnt++;
    end
    check("abort_no_done_no_write", cnt, 0);

    // init during APPLY behaves like reset
    do_tick(5'b00100, 1'b0, 0, 0, fa, nw);
    @(negedge clock);
    drive_cmd(5'b00100); start = 1;
    @(negedge clock);
    start = 0; init = 1;
    @(negedge clock);
    init = 0;
    model_reset();
    check("init_busy", int'(busy), 0);
    check("init_xy", int'({x_pos, y_pos}), int'({9'd1, 8'd96}));
    cnt = 0;
    repeat (280) begin
      @(negedge clock);
      if (done === 1'b1) cnt++;
    end
    check("init_no_done", cnt, 0);

    // clamping at the far edges
    e_tick(5'b00001, 1'b0, 303, 222, 3);
    e_tick(5'b00001, 1'b0, 303, 222, 3);
    e_tick(5'b00100, 1'b0, 303, 223, 0);
    e_tick(5'b00100, 1'b0, 303, 223, 0);
    e_tick(5'b01000, 1'b1, 303, 223, 2);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      rc = r == 0 ? 5'b00000 : r == 1 ? 5'b10000 : r <= 5 ? 5'(1 << (r - 2)) : 5'($urandom);
      do_tick(rc, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
              $urandom_range(0, 3) == 0 ? 60 : $urandom_range(0, 3) == 0 ? 259 : 0, fa, nw);
      check("rand_frame", (fa / 256) % 2, mfr);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
